bcd_divisibility_checker: RTL and testbench

Sequential, parametrised divisibility tester for multi-digit BCD numbers; next generation of the team's fixed 4-digit divide-by-11 checker. Digits stream in most-significant first over a valid/ready handshake, one per cycle at most. A running remainder modulo a configurable divisor is kept, and a registered verdict and remainder are produced after the last digit. It sits between BCD digit sources (keypad/serial front ends) and display/compare logic in the lab designs.

---
 rtl/bcd_div_pkg.sv | 18 +
 rtl/bcd_mod_step.sv | 29 ++
 rtl/bcd_divisibility_checker.sv | 121 ++++++++++++
 tb/tb_bcd_divisibility_checker.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_div_pkg.sv
// Shared types and constants for the BCD divisibility checker.
// Consumed by bcd_mod_step and bcd_divisibility_checker.
package bcd_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } stateT;

    localparam int BCD_RADIX     = 10;
    localparam int BCD_MAX_DIGIT = 9;

    function automatic bit paramsLegal(input int digits, input int divisor);
        return (digits >= 1) && (digits <= 16) && (divisor >= 2) && (divisor <= 99);
    endfunction

endpackage

// File: rtl/bcd_mod_step.sv
// One MSD-first remainder step: nextRem = (rem*10 + digit) mod DIVISOR.
// Purely combinational; reduces by subtracting the largest k*DIVISOR, k = 0..10.
module bcd_mod_step
    import bcd_div_pkg::*;
#(
    parameter int DIVISOR = 11,
    localparam int REM_W = $clog2(DIVISOR)
) (
    input  logic [REM_W-1:0] rem,
    input  logic [3:0]       digit,
    output logic [REM_W-1:0] nextRem
);

    // rem*10 + digit never reaches 10*DIVISOR + 6, even for raw digits up to 15
    localparam int SUM_W = $clog2(BCD_RADIX * DIVISOR + 6);

    logic [SUM_W-1:0] sum;

    always_comb begin
        sum     = SUM_W'(rem) * SUM_W'(BCD_RADIX) + SUM_W'(digit);
        nextRem = REM_W'(sum);
        for (int k = 1; k <= BCD_RADIX; k++) begin
            if (sum >= SUM_W'(k * DIVISOR)) begin
                nextRem = REM_W'(sum - SUM_W'(k * DIVISOR));
            end
        end
    end

endmodule

// File: rtl/bcd_divisibility_checker.sv
// Streams DIGITS BCD digits (MSD first) and reports operand mod DIVISOR.
// Optional BCD_CHECK_EN adds a sticky bcdError flag for digits above 9.
//
// state | meaning
// IDLE  | waiting for start, no digits accepted
// ACCUM | accepting digits, running remainder updated on each transfer
// DONE  | one cycle, result registers just updated, done pulses
module bcd_divisibility_checker
    import bcd_div_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DIVISOR = 11,
    localparam int REM_W  = $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             digitValid,
    input  logic [3:0]       digit,
    output logic             digitReady,
    output logic             busy,
    output logic             done,
    output logic             isDivider,
`ifdef BCD_CHECK_EN
    output logic             bcdError,
`endif
    output logic [REM_W-1:0] remainder
);

    localparam int CNT_W = $clog2(DIGITS + 1);

    if (!paramsLegal(DIGITS, DIVISOR)) begin : gParamCheck
        $error("bcd_divisibility_checker: DIGITS must be 1..16, DIVISOR 2..99");
    end

    stateT            state, nextState;
    logic [REM_W-1:0] rem, nextRem;
    logic [CNT_W-1:0] cnt;
    logic             xfer, lastDigit;

    assign xfer      = (state == ACCUM) && digitValid;
    assign lastDigit = (cnt == CNT_W'(DIGITS - 1));

    bcd_mod_step #(.DIVISOR(DIVISOR)) uModStep (
        .rem     (rem),
        .digit   (digit),
        .nextRem (nextRem)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = ACCUM;
            ACCUM: begin
                if (start)                  nextState = ACCUM;
                else if (xfer && lastDigit) nextState = DONE;
            end
            DONE:    nextState = start ? ACCUM : IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        digitReady = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ACCUM: begin
                digitReady = 1'b1;
                busy       = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

`ifdef BCD_CHECK_EN
    logic digitBad;
    assign digitBad = digit > 4'(BCD_MAX_DIGIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            bcdError <= 1'b0;
        end else if (start) begin
            bcdError <= 1'b0;
        end else if (xfer && digitBad) begin
            bcdError <= 1'b1;
        end
    end
`endif

    // start wins over a same-cycle transfer, so an aborted operand leaves no trace
    always_ff @(posedge clk) begin
        if (rst) begin
            rem       <= '0;
            cnt       <= '0;
            isDivider <= 1'b0;
            remainder <= '0;
        end else if (start) begin
            rem <= '0;
            cnt <= '0;
        end else if (xfer) begin
            rem <= nextRem;
            cnt <= cnt + 1'b1;
            if (lastDigit) begin
                remainder <= nextRem;
`ifdef BCD_CHECK_EN
                isDivider <= (nextRem == '0) && !bcdError && !digitBad;
`else
                isDivider <= (nextRem == '0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_bcd_divisibility_checker.sv
// Self-checking bench: DIVISOR=11/DIGITS=4 and DIVISOR=7/DIGITS=3 instances
// against an integer-arithmetic model; honours BCD_CHECK_EN when defined.
module tb_bcd_divisibility_checker;

    logic             clk;
    logic             rst;
    logic [1:0]       start;
    logic [1:0]       digitValid;
    logic [1:0][3:0]  digitIn;
    logic [1:0]       readyW, busyW, doneW, divW;
    logic [3:0]       rem11;
    logic [2:0]       rem7;
`ifdef BCD_CHECK_EN
    logic [1:0]       errW;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int divs [2]    = '{11, 7};
    int nDig [2]    = '{4, 3};
    int prevRem [2] = '{0, 0};
    int prevDiv [2] = '{0, 0};

    bcd_divisibility_checker #(.DIGITS(4), .DIVISOR(11)) dut11 (
        .clk        (clk),
        .rst        (rst),
        .start      (start[0]),
        .digitValid (digitValid[0]),
        .digit      (digitIn[0]),
        .digitReady (readyW[0]),
        .busy       (busyW[0]),
        .done       (doneW[0]),
        .isDivider  (divW[0]),
`ifdef BCD_CHECK_EN
        .bcdError   (errW[0]),
`endif
        .remainder  (rem11)
    );

    bcd_divisibility_checker #(.DIGITS(3), .DIVISOR(7)) dut7 (
        .clk        (clk),
        .rst        (rst),
        .start      (start[1]),
        .digitValid (digitValid[1]),
        .digit      (digitIn[1]),
        .digitReady (readyW[1]),
        .busy       (busyW[1]),
        .done       (doneW[1]),
        .isDivider  (divW[1]),
`ifdef BCD_CHECK_EN
        .bcdError   (errW[1]),
`endif
        .remainder  (rem7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] remOf(input int idx);
        return (idx == 0) ? 32'(rem11) : 32'(rem7);
    endfunction

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[dut%0d]: observed %0d expected %0d", tag, divs[idx], obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag, input int idx);
        check({tag, " done"}, idx, 32'(doneW[idx]), 32'd0);
        check({tag, " busy"}, idx, 32'(busyW[idx]), 32'd0);
        check({tag, " ready"}, idx, 32'(readyW[idx]), 32'd0);
        check({tag, " isDivider"}, idx, 32'(divW[idx]), 32'd0);
        check({tag, " remainder"}, idx, remOf(idx), 32'd0);
`ifdef BCD_CHECK_EN
        check({tag, " bcdError"}, idx, 32'(errW[idx]), 32'd0);
`endif
    endtask

    // Caller sits at a negedge with the DUT in IDLE, DONE or ACCUM; returns at the DONE negedge.
    task automatic doOp(input int idx, input logic [63:0] digs, input int gapPos, input int gapLen);
        int         n;
        longint     val;
        bit         expErr;
        int         expRem;
        int         expDiv;
        logic [3:0] d;
        n      = nDig[idx];
        val    = 0;
        expErr = 0;
        for (int i = 0; i < n; i++) begin
            d   = digs[4*(n-1-i) +: 4];
            val = val * 10 + longint'(d);
            if (d > 4'd9) expErr = 1;
        end
        expRem = int'(val % longint'(divs[idx]));
`ifdef BCD_CHECK_EN
        expDiv = (expRem == 0 && !expErr) ? 1 : 0;
`else
        expDiv = (expRem == 0) ? 1 : 0;
`endif
        start[idx]      = 1'b1;
        digitValid[idx] = 1'b1;
        digitIn[idx]    = 4'd9;
        @(negedge clk);
        start[idx]      = 1'b0;
        digitValid[idx] = 1'b0;
        check("accum busy", idx, 32'(busyW[idx]), 32'd1);
        check("accum ready", idx, 32'(readyW[idx]), 32'd1);
        check("accum no done", idx, 32'(doneW[idx]), 32'd0);
        check("hold remainder", idx, remOf(idx), 32'(prevRem[idx]));
        check("hold isDivider", idx, 32'(divW[idx]), 32'(prevDiv[idx]));
`ifdef BCD_CHECK_EN
        check("start clears bcdError", idx, 32'(errW[idx]), 32'd0);
`endif
        for (int i = 0; i < n; i++) begin
            if (i == gapPos) begin
                digitValid[idx] = 1'b0;
                repeat (gapLen) begin
                    @(negedge clk);
                    check("gap no done", idx, 32'(doneW[idx]), 32'd0);
                    check("gap ready", idx, 32'(readyW[idx]), 32'd1);
                end
            end
            digitValid[idx] = 1'b1;
            digitIn[idx]    = digs[4*(n-1-i) +: 4];
            @(negedge clk);
            if (i < n - 1) check("early done", idx, 32'(doneW[idx]), 32'd0);
        end
        digitValid[idx] = 1'b0;
        check("done pulse", idx, 32'(doneW[idx]), 32'd1);
        check("done busy", idx, 32'(busyW[idx]), 32'd0);
        check("done ready", idx, 32'(readyW[idx]), 32'd0);
        check("isDivider", idx, 32'(divW[idx]), 32'(expDiv));
        check("remainder", idx, remOf(idx), 32'(expRem));
`ifdef BCD_CHECK_EN
        check("bcdError", idx, 32'(errW[idx]), 32'(expErr));
`endif
        prevRem[idx] = expRem;
        prevDiv[idx] = expDiv;
    endtask

    initial begin
        logic [63:0] rnd;
        int          idx;
        int          n;
        rst        = 1'b1;
        start      = '0;
        digitValid = '0;
        digitIn    = '0;
        repeat (2) @(negedge clk);
        start = 2'b11;
        @(negedge clk);
        checkIdle("reset", 0);
        checkIdle("reset", 1);
        start = '0;
        rst   = 1'b0;
        @(negedge clk);

        doOp(0, 64'h0000, -1, 0);
        doOp(0, 64'h0099, -1, 0);
        doOp(0, 64'h0909, -1, 0);
        doOp(0, 64'h0011, -1, 0);
        doOp(0, 64'h1234, -1, 0);
        doOp(0, 64'h0000, -1, 0);
        doOp(0, 64'h0909, 2, 3);
        @(negedge clk);
        check("done one cycle", 0, 32'(doneW[0]), 32'd0);

        // Abort: two digits of 1234 then restart with 0011
        start[0] = 1'b1;
        @(negedge clk);
        start[0]      = 1'b0;
        digitValid[0] = 1'b1;
        digitIn[0]    = 4'd1;
        @(negedge clk);
        digitIn[0] = 4'd2;
        @(negedge clk);
        check("abort no done", 0, 32'(doneW[0]), 32'd0);
        doOp(0, 64'h0011, -1, 0);

        // Reset mid-operand
        start[0] = 1'b1;
        @(negedge clk);
        start[0]      = 1'b0;
        digitValid[0] = 1'b1;
        digitIn[0]    = 4'd5;
        @(negedge clk);
        digitIn[0] = 4'd6;
        @(negedge clk);
        digitValid[0] = 1'b0;
        rst           = 1'b1;
        start         = 2'b01;
        @(negedge clk);
        checkIdle("mid reset", 0);
        checkIdle("mid reset", 1);
        rst     = 1'b0;
        start   = '0;
        prevRem = '{0, 0};
        prevDiv = '{0, 0};
        @(negedge clk);

        doOp(1, 64'h343, -1, 0);
        doOp(1, 64'h100, -1, 0);
        doOp(0, 64'h0A11, -1, 0);
        doOp(0, 64'h0011, 1, 2);

        for (int it = 0; it < 150; it++) begin
            idx = int'($urandom_range(0, 1));
            n   = nDig[idx];
            rnd = '0;
            for (int i = 0; i < n; i++) begin
                rnd = rnd << 4;
                if ($urandom_range(0, 7) == 0) rnd[3:0] = 4'($urandom_range(10, 15));
                else                           rnd[3:0] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 5) == 0) rnd = 64'h0;
            doOp(idx, rnd, int'($urandom_range(0, n)), int'($urandom_range(1, 3)));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
